// File: rtl/mc_decn_cnt_pkg.sv
// Shared constants and FSM encoding for the split-borrow timing down-counter.
package mc_decn_cnt_pkg;

    localparam int DECN_WIDTH = 16;

    typedef enum logic {
        DECN_IDLE = 1'b0,
        DECN_RUN  = 1'b1
    } decn_state_e;

endpackage

// File: rtl/mc_decn_half.sv
// Registered half-width decrementer: subtracts borrow-in per enabled cycle and
// registers the borrow it produces so the next half sees it one cycle later.
module mc_decn_half #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    input  logic         bin,
    output logic [W-1:0] q,
    output logic         bout
);

    // Load overrides stepping; a disabled cycle holds value and pending borrow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            bout <= 1'b0;
        end else if (ld) begin
            q    <= ld_val;
            bout <= 1'b0;
        end else if (en) begin
            q    <= q - W'(bin);
            bout <= bin && (q == '0);
        end
    end

endmodule

// File: rtl/mc_decn_cnt.sv
// Loadable pipelined down-counter with start/busy/done handshake and optional
// periodic auto-reload; the lower-half borrow reaches the upper half a cycle late.
module mc_decn_cnt
    import mc_decn_cnt_pkg::*;
#(
    parameter int WIDTH  = DECN_WIDTH,
    parameter int CENTER = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             rld_mode,
    input  logic             dec_en,
    output logic             busy,
    output logic             zero,
    output logic             done,
    output logic [WIDTH-1:0] cnt
);

    localparam int HW = WIDTH - CENTER;

    decn_state_e         state;
    decn_state_e         state_nx;
    logic [CENTER-1:0]   lo;
    logic [HW-1:0]       hi;
    logic                bpend;
    logic                hi_wrap;
    logic [WIDTH-1:0]    rld;
    logic                done_r;
    logic                done_nx;
    logic                step;
    logic                dec_now;
    logic                reload_now;
    logic                at_one;
    logic                half_ld;
    logic [WIDTH-1:0]    half_val;

    // A hi wrap is unreachable; it is folded into zero so a corrupted count never reads as expired.
    assign zero   = (lo == '0) && (hi == '0) && !bpend && !hi_wrap;
    assign at_one = (lo == CENTER'(1)) && (hi == '0) && !bpend;
    assign step       = (state == DECN_RUN) && dec_en && !ld;
    assign dec_now    = step && !zero;
    assign reload_now = step && zero;
    assign half_ld    = ld || reload_now;
    assign half_val   = ld ? ld_val : rld;

    assign cnt  = {hi - HW'(bpend), lo};
    assign busy = (state == DECN_RUN);
    assign done = done_r;

    mc_decn_half #(.W(CENTER)) u_lo (
        .clk    (clk),
        .rst    (rst),
        .ld     (half_ld),
        .ld_val (half_val[CENTER-1:0]),
        .en     (dec_now),
        .bin    (1'b1),
        .q      (lo),
        .bout   (bpend)
    );

    mc_decn_half #(.W(HW)) u_hi (
        .clk    (clk),
        .rst    (rst),
        .ld     (half_ld),
        .ld_val (half_val[WIDTH-1:CENTER]),
        .en     (dec_now),
        .bin    (bpend),
        .q      (hi),
        .bout   (hi_wrap)
    );

    // Reload value is captured only by an explicit load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rld <= '0;
        end else if (ld) begin
            rld <= ld_val;
        end
    end

    // FSM state and registered done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= DECN_IDLE;
            done_r <= 1'b0;
        end else begin
            state  <= state_nx;
            done_r <= done_nx;
        end
    end

    // Next state: load wins; the terminal step pulses done and either stops or arms a reload.
    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        if (ld) begin
            if (ld_val != '0) begin
                state_nx = DECN_RUN;
            end else begin
                state_nx = DECN_IDLE;
                done_nx  = 1'b1;
            end
        end else begin
            case (state)
                DECN_RUN: begin
                    if (reload_now) begin
                        state_nx = (rld != '0) ? DECN_RUN : DECN_IDLE;
                    end else if (dec_now && at_one) begin
                        done_nx = 1'b1;
                        if (!rld_mode || (rld == '0)) begin
                            state_nx = DECN_IDLE;
                        end else begin
                            state_nx = DECN_RUN;
                        end
                    end else begin
                        state_nx = DECN_RUN;
                    end
                end
                DECN_IDLE: begin
                    state_nx = DECN_IDLE;
                end
                default: begin
                    state_nx = DECN_IDLE;
                end
            endcase
        end
    end

endmodule
